// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit: iterative radix-2 shift-add multiply and
// restoring divide, with MTHI/MTLO access and pipeline flush.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_d;
  logic             busy_d, done_d;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic               accept;
  logic               in_sa, in_sb, sa, sb, is_div, div_zero;
  logic [WIDTH-1:0]   in_a_mag, in_b_mag, a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, r_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s, res_hi, res_lo;

  assign accept = (state == IDLE) && start && !flush;

  // Operand signs and magnitudes, both at launch and from the latched copies
  always_comb begin
    in_sa    = ~op[0] & a[WIDTH-1];
    in_sb    = ~op[0] & b[WIDTH-1];
    in_a_mag = in_sa ? -a : a;
    in_b_mag = in_sb ? -b : b;
    is_div   = op_r[1];
    sa       = ~op_r[0] & a_r[WIDTH-1];
    sb       = ~op_r[0] & b_r[WIDTH-1];
    a_mag    = sa ? -a_r : a_r;
    b_mag    = sb ? -b_r : b_r;
    div_zero = is_div && (b_r == '0);
  end

  // One radix-2 step: shift-add for multiply, restoring trial subtract for divide
  always_comb begin
    mul_sum = acc_hi + (acc_lo[0] ? {1'b0, a_mag} : '0);
    r_sh    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    diff    = {1'b0, r_sh} - {2'b00, b_mag};
  end

  // Sign fix-up of the final magnitudes; divide-by-zero bypasses it
  always_comb begin
    prod   = {acc_hi[WIDTH-1:0], acc_lo};
    prod_s = (sa ^ sb) ? -prod : prod;
    q_s    = (sa ^ sb) ? -acc_lo : acc_lo;
    r_s    = sa ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (div_zero) begin
      res_hi = a_r;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = r_s;
      res_lo = q_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          state_d = CALC;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt == CW'(1)) begin
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = !flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration counter and shift registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept) begin
      op_r   <= op;
      a_r    <= a;
      b_r    <= b;
      cnt    <= CW'(WIDTH);
      acc_hi <= '0;
      acc_lo <= op[1] ? in_a_mag : in_b_mag;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (is_div) begin
        if (!diff[WIDTH+1]) begin
          acc_hi <= diff[WIDTH:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= r_sh;
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi <= {1'b0, mul_sum[WIDTH:1]};
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // HI/LO: result write in DONE, MTHI/MTLO only in IDLE without a start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      if (!flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (state == IDLE && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; legal values are even integers of 4 or more.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; the block SHALL be in reset while reset=0.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  WIDTH  first operand (multiplicand or dividend).
REQ-007 b  input  WIDTH  second operand (multiplier or divisor).
REQ-008 flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 hi_we  input  1  MTHI strobe.
REQ-010 lo_we  input  1  MTLO strobe.
REQ-011 wdata  input  WIDTH  data for MTHI/MTLO.
REQ-012 busy  output  1  high while an operation is in flight; the pipeline SHALL stall MFHI/MFLO while it is high.
REQ-013 done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-014 hi  output  WIDTH  HI register: upper product half or remainder.
REQ-015 lo  output  WIDTH  LO register: lower product half or quotient.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-017 In IDLE, start=1 with flush=0 SHALL latch a, b and op, and SHALL load the iteration counter with WIDTH.
REQ-018 That same start SHALL cause a move to CALC, and busy SHALL be 1 from the following cycle.
REQ-019 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-020 In CALC the counter SHALL decrement once per cycle, and the FSM SHALL move to DONE when it reaches 0, i.e. after exactly WIDTH CALC cycles.
REQ-021 In DONE the block SHALL apply the sign fix-up, write hi/lo, assert done for one cycle with busy=0, and return to IDLE.
REQ-022 Latency: if start is sampled at edge N, done=1 and the new hi/lo values SHALL be visible in the cycle after edge N+WIDTH+1.
REQ-023 Signed multiply: the 2*WIDTH product SHALL be negated when the operand signs differ.
REQ-024 Signed divide: the quotient sign SHALL equal sign(a) XOR sign(b), and the remainder sign SHALL equal sign(a).
REQ-025 Signed overflow (a = most-negative value, b = -1) SHALL give lo = most-negative value and hi = 0.
REQ-026 Divide by zero (DIV or DIVU) SHALL give lo = all ones and hi = a, with the sign fix-up bypassed; the full latency and the done pulse still apply.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 flush=1 in CALC or DONE SHALL return the FSM to IDLE at the next edge, with no done pulse and hi/lo unchanged.
REQ-029 flush=1 together with start in IDLE SHALL win: no operation is started.
REQ-030 In IDLE, hi_we and lo_we SHALL write wdata into hi and lo respectively at the next edge; both may be asserted in the same cycle.
REQ-031 hi_we and lo_we SHALL be ignored while busy=1 or in DONE.
REQ-032 In IDLE, start SHALL take precedence over hi_we and lo_we asserted in the same cycle, and those writes SHALL be dropped.
REQ-033 Operand inputs SHALL be don't-care outside the start cycle.

Reset
REQ-034 While reset=0, the FSM SHALL be in IDLE, busy=0, done=0, hi=0, lo=0, and the counter and datapath registers SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abort it immediately, with no done pulse after release.
REQ-036 The first start SHALL be accepted at the first rising edge with reset=1.

Verification
REQ-037 WIDTH=32, MULT a=0xFFFFFFFD (-3), b=5 -> done after 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, done pulses once.
REQ-041 MTHI 0xAAAA0000 in IDLE, start MULT, flush at CALC cycle 10 -> no done, hi=0xAAAA0000, and a new start is accepted on the next cycle.
REQ-042 reset=0 at CALC cycle 5 -> busy=0 and hi=lo=0 immediately; a start pulse while busy=1 and an hi_we while busy=1 are both ignored.
